// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - word-addressed data memory with fixed, parameterised response latency
//
// Ports:
//   clk, rst                   clock, asynchronous active-high reset
//   req_valid / req_ready      request handshake (ready depends on state only)
//   req_write, req_addr,       request: store/load select, word address, store data
//   req_wdata
//   resp_valid                 one-cycle response pulse (no backpressure)
//   resp_write, resp_rdata     registered response: echoed write flag, load data (0 for stores)
module dmem_responder #(
    parameter int ADDR_W  = 7,
    parameter int DATA_W  = 32,
    parameter int LATENCY = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic              resp_write,
    output logic [DATA_W-1:0] resp_rdata
);

    localparam int DEPTH = 1 << ADDR_W;
    // Counter preload; the WAIT state itself accounts for one of the LATENCY edges
    // and the RESP entry for another.
    localparam logic [3:0] CNT_LOAD = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic                lat_write_q, lat_write_d;
    logic [ADDR_W-1:0]   lat_addr_q, lat_addr_d;
    logic [DATA_W-1:0]   lat_wdata_q, lat_wdata_d;
    logic                resp_write_q, resp_write_d;
    logic [DATA_W-1:0]   resp_rdata_q, resp_rdata_d;
    logic [DATA_W-1:0]   mem_q [DEPTH];

    logic                accept;
    logic                enter_resp;
    logic                acc_write;
    logic [ADDR_W-1:0]   acc_addr;
    logic [DATA_W-1:0]   acc_wdata;
    logic                mem_we;

    assign req_ready  = (state_q != WAIT);
    assign accept     = req_valid && req_ready;
    assign resp_valid = (state_q == RESP);
    assign resp_write = resp_write_q;
    assign resp_rdata = resp_rdata_q;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        lat_write_d  = lat_write_q;
        lat_addr_d   = lat_addr_q;
        lat_wdata_d  = lat_wdata_q;
        resp_write_d = resp_write_q;
        resp_rdata_d = resp_rdata_q;

        case (state_q)
            IDLE, RESP: begin
                if (accept) begin
                    lat_write_d = req_write;
                    lat_addr_d  = req_addr;
                    lat_wdata_d = req_wdata;
                    if (LATENCY == 1) begin
                        state_d = RESP;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = CNT_LOAD;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Entering RESP from WAIT uses the latched request. With LATENCY = 1 the
        // RESP entry is the accept edge itself, so the live request inputs are
        // used instead (they are what is being latched on that same edge).
        enter_resp = (state_d == RESP);
        if (state_q == WAIT) begin
            acc_write = lat_write_q;
            acc_addr  = lat_addr_q;
            acc_wdata = lat_wdata_q;
        end else begin
            acc_write = req_write;
            acc_addr  = req_addr;
            acc_wdata = req_wdata;
        end

        mem_we = enter_resp && acc_write;
        if (enter_resp) begin
            resp_write_d = acc_write;
            resp_rdata_d = acc_write ? '0 : mem_q[acc_addr];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= 4'd0;
            lat_write_q  <= 1'b0;
            lat_addr_q   <= '0;
            lat_wdata_q  <= '0;
            resp_write_q <= 1'b0;
            resp_rdata_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            lat_write_q  <= lat_write_d;
            lat_addr_q   <= lat_addr_d;
            lat_wdata_q  <= lat_wdata_d;
            resp_write_q <= resp_write_d;
            resp_rdata_q <= resp_rdata_d;
            if (mem_we) begin
                mem_q[acc_addr] <= acc_wdata;
            end
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - self-checking bench for dmem_responder at LATENCY 1, 2 and 3
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid  [3];
    logic        req_ready  [3];
    logic        req_write  [3];
    logic [6:0]  req_addr   [3];
    logic [31:0] req_wdata  [3];
    logic        resp_valid [3];
    logic        resp_write [3];
    logic [31:0] resp_rdata [3];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Instance g has LATENCY g+1.
    for (genvar g = 0; g < 3; g++) begin : g_dut
        dmem_responder #(.ADDR_W(7), .DATA_W(32), .LATENCY(g + 1)) u_dut (
            .clk        (clk),
            .rst        (rst),
            .req_valid  (req_valid[g]),
            .req_ready  (req_ready[g]),
            .req_write  (req_write[g]),
            .req_addr   (req_addr[g]),
            .req_wdata  (req_wdata[g]),
            .resp_valid (resp_valid[g]),
            .resp_write (resp_write[g]),
            .resp_rdata (resp_rdata[g])
        );
    end

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endfunction

    // Reference model: a request accepted in cycle k responds in cycle k+LAT,
    // the memory is read/written at that response, and the block is busy
    // until then. Response fields persist until the next response.
    logic [31:0] mmem [3][128];
    logic        m_pend [3];
    int          m_due  [3];
    logic        m_w    [3];
    logic [6:0]  m_a    [3];
    logic [31:0] m_d    [3];
    logic        m_lw   [3];
    logic [31:0] m_lr   [3];

    always @(negedge clk) begin : monitor
        logic er, ev, rn;
        for (int i = 0; i < 3; i++) begin
            if (rst) begin
                for (int a = 0; a < 128; a++) mmem[i][a] = 32'h0;
                m_pend[i] = 1'b0;
                m_lw[i]   = 1'b0;
                m_lr[i]   = 32'h0;
                er = 1'b1;
                ev = 1'b0;
            end else begin
                rn = m_pend[i] && (m_due[i] == cyc);
                ev = rn;
                er = !m_pend[i] || rn;
                if (rn) begin
                    if (m_w[i]) begin
                        mmem[i][m_a[i]] = m_d[i];
                        m_lw[i] = 1'b1;
                        m_lr[i] = 32'h0;
                    end else begin
                        m_lw[i] = 1'b0;
                        m_lr[i] = mmem[i][m_a[i]];
                    end
                    m_pend[i] = 1'b0;
                end
            end
            chk($sformatf("mon%0d_ready", i), 32'(req_ready[i]), 32'(er));
            chk($sformatf("mon%0d_valid", i), 32'(resp_valid[i]), 32'(ev));
            chk($sformatf("mon%0d_write", i), 32'(resp_write[i]), 32'(m_lw[i]));
            chk($sformatf("mon%0d_rdata", i), resp_rdata[i], m_lr[i]);
            if (!rst && req_valid[i] && er) begin
                m_pend[i] = 1'b1;
                m_due[i]  = cyc + i + 1;
                m_w[i]    = req_write[i];
                m_a[i]    = req_addr[i];
                m_d[i]    = req_wdata[i];
            end
        end
    end

    // All tasks start and end aligned 1 time unit after a rising edge.
    task automatic issue_only(input int i, input logic w, input logic [6:0] a, input logic [31:0] d);
        int n = 0;
        req_valid[i] = 1'b1;
        req_write[i] = w;
        req_addr[i]  = a;
        req_wdata[i] = d;
        do begin
            @(negedge clk);
            n++;
        end while (!req_ready[i] && n < 50);
        if (n >= 50) chk($sformatf("accept_timeout%0d", i), 32'(n), 32'(0));
        @(posedge clk);
        #1;
        req_valid[i] = 1'b0;
    endtask

    task automatic wait_resp(input int i, output logic ow, output logic [31:0] ord, output int lat);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!resp_valid[i] && lat < 40);
        if (lat >= 40) chk($sformatf("resp_timeout%0d", i), 32'(lat), 32'(0));
        ow  = resp_write[i];
        ord = resp_rdata[i];
        @(posedge clk);
        #1;
    endtask

    task automatic run_req(input int i, input logic w, input logic [6:0] a, input logic [31:0] d,
                           output logic ow, output logic [31:0] ord, output int lat);
        issue_only(i, w, a, d);
        wait_resp(i, ow, ord, lat);
    endtask

    task automatic to_drive();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        int          inst;
        logic        wr;
        logic [6:0]  addr;
        logic [31:0] wdata;
        logic        exp_w;
        logic [31:0] exp_r;
    } vec_t;

    vec_t vecs [9];

    initial begin : stim
        logic        ow;
        logic [31:0] ord;
        int          lat;

        vecs[0] = '{1, 1'b0, 7'h7F, 32'h0,        1'b0, 32'h0};
        vecs[1] = '{1, 1'b1, 7'h05, 32'hDEADBEEF, 1'b1, 32'h0};
        vecs[2] = '{1, 1'b0, 7'h05, 32'h0,        1'b0, 32'hDEADBEEF};
        vecs[3] = '{0, 1'b1, 7'h00, 32'h0000000A, 1'b1, 32'h0};
        vecs[4] = '{0, 1'b1, 7'h01, 32'h0000000B, 1'b1, 32'h0};
        vecs[5] = '{0, 1'b1, 7'h02, 32'h0000000C, 1'b1, 32'h0};
        vecs[6] = '{2, 1'b1, 7'h33, 32'h55AA55AA, 1'b1, 32'h0};
        vecs[7] = '{2, 1'b0, 7'h33, 32'h0,        1'b0, 32'h55AA55AA};
        vecs[8] = '{0, 1'b0, 7'h7F, 32'h0,        1'b0, 32'h0};

        for (int i = 0; i < 3; i++) begin
            req_valid[i] = 1'b0;
            req_write[i] = 1'b0;
            req_addr[i]  = 7'h0;
            req_wdata[i] = 32'h0;
        end

        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("rst_ready%0d", i), 32'(req_ready[i]), 32'd1);
            chk($sformatf("rst_valid%0d", i), 32'(resp_valid[i]), 32'd0);
            chk($sformatf("rst_rdata%0d", i), resp_rdata[i], 32'h0);
        end
        repeat (2) to_drive();
        rst = 1'b0;
        to_drive();

        // Table-driven single requests.
        for (int v = 0; v < 9; v++) begin
            run_req(vecs[v].inst, vecs[v].wr, vecs[v].addr, vecs[v].wdata, ow, ord, lat);
            chk($sformatf("vec%0d_write", v), 32'(ow), 32'(vecs[v].exp_w));
            chk($sformatf("vec%0d_rdata", v), ord, vecs[v].exp_r);
            chk($sformatf("vec%0d_latency", v), 32'(lat), 32'(vecs[v].inst + 1));
        end

        // LATENCY 3: store then load of the same address held pending.
        req_valid[2] = 1'b1;
        req_write[2] = 1'b1;
        req_addr[2]  = 7'h10;
        req_wdata[2] = 32'h12345678;
        @(negedge clk);
        chk("b2b_ready_idle", 32'(req_ready[2]), 32'd1);
        to_drive();
        req_write[2] = 1'b0;
        req_wdata[2] = 32'h0;
        @(negedge clk);
        chk("b2b_wait1_ready", 32'(req_ready[2]), 32'd0);
        chk("b2b_wait1_valid", 32'(resp_valid[2]), 32'd0);
        @(negedge clk);
        chk("b2b_wait2_ready", 32'(req_ready[2]), 32'd0);
        @(negedge clk);
        chk("b2b_st_ready", 32'(req_ready[2]), 32'd1);
        chk("b2b_st_valid", 32'(resp_valid[2]), 32'd1);
        chk("b2b_st_write", 32'(resp_write[2]), 32'd1);
        chk("b2b_st_rdata", resp_rdata[2], 32'h0);
        to_drive();
        req_valid[2] = 1'b0;
        repeat (2) begin
            @(negedge clk);
            chk("b2b_ld_wait_valid", 32'(resp_valid[2]), 32'd0);
        end
        @(negedge clk);
        chk("b2b_ld_valid", 32'(resp_valid[2]), 32'd1);
        chk("b2b_ld_write", 32'(resp_write[2]), 32'd0);
        chk("b2b_ld_rdata", resp_rdata[2], 32'h12345678);
        to_drive();

        // LATENCY 1: three consecutive loads, one per cycle.
        req_valid[0] = 1'b1;
        req_write[0] = 1'b0;
        req_addr[0]  = 7'h00;
        @(negedge clk);
        chk("l1_pre_valid", 32'(resp_valid[0]), 32'd0);
        to_drive();
        req_addr[0] = 7'h01;
        @(negedge clk);
        chk("l1_r0_valid", 32'(resp_valid[0]), 32'd1);
        chk("l1_r0_rdata", resp_rdata[0], 32'hA);
        to_drive();
        req_addr[0] = 7'h02;
        @(negedge clk);
        chk("l1_r1_valid", 32'(resp_valid[0]), 32'd1);
        chk("l1_r1_rdata", resp_rdata[0], 32'hB);
        to_drive();
        req_valid[0] = 1'b0;
        @(negedge clk);
        chk("l1_r2_valid", 32'(resp_valid[0]), 32'd1);
        chk("l1_r2_rdata", resp_rdata[0], 32'hC);
        to_drive();
        @(negedge clk);
        chk("l1_post_valid", 32'(resp_valid[0]), 32'd0);
        to_drive();

        // LATENCY 2: request inputs change after accept; latched values win.
        issue_only(1, 1'b1, 7'h0F, 32'h11111111);
        req_addr[1]  = 7'h0E;
        req_wdata[1] = 32'h22222222;
        wait_resp(1, ow, ord, lat);
        chk("chg_st_write", 32'(ow), 32'd1);
        run_req(1, 1'b0, 7'h0F, 32'h0, ow, ord, lat);
        chk("chg_ld_latched", ord, 32'h11111111);
        run_req(1, 1'b0, 7'h0E, 32'h0, ow, ord, lat);
        chk("chg_ld_other", ord, 32'h0);

        // Random traffic, checked by the monitor model.
        for (int i = 0; i < 3; i++) begin
            for (int k = 0; k < 60; k++) begin
                issue_only(i, 1'($urandom_range(0, 1)), 7'($urandom_range(0, 15)), $urandom);
                repeat ($urandom_range(0, 2)) to_drive();
            end
            repeat (20) to_drive();
        end

        // Reset during WAIT of a store: dropped, no response, no write.
        issue_only(2, 1'b1, 7'h20, 32'hFFFFFFFF);
        @(negedge clk);
        chk("rstw_ready_wait", 32'(req_ready[2]), 32'd0);
        to_drive();
        rst = 1'b1;
        @(negedge clk);
        chk("rstw_ready", 32'(req_ready[2]), 32'd1);
        chk("rstw_valid", 32'(resp_valid[2]), 32'd0);
        chk("rstw_write", 32'(resp_write[2]), 32'd0);
        chk("rstw_rdata", resp_rdata[2], 32'h0);
        to_drive();
        rst = 1'b0;
        repeat (5) begin
            @(negedge clk);
            chk("rstw_no_pulse", 32'(resp_valid[2]), 32'd0);
        end
        to_drive();
        run_req(2, 1'b0, 7'h20, 32'h0, ow, ord, lat);
        chk("rstw_ld_rdata", ord, 32'h0);
        chk("rstw_ld_write", 32'(ow), 32'd0);

        repeat (3) to_drive();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
